// File: rtl/reservation_station_if.sv
// Dispatch, wakeup and issue signals between the front end, the reservation
// station and fu_wrapper's issue port.
interface reservation_station_if #(
    parameter int SS        = 2,
    parameter int RS_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 128
);
    localparam int FC_W = $clog2(RS_DEPTH) + 1;

    logic [SS-1:0]                dispatch_valid;
    logic [SS-1:0][PAYLOAD_W-1:0] dispatch_payload;
    logic [SS-1:0][PREG_W-1:0]    dispatch_rs1_preg;
    logic [SS-1:0][PREG_W-1:0]    dispatch_rs2_preg;
    logic [SS-1:0]                dispatch_rs1_ready;
    logic [SS-1:0]                dispatch_rs2_ready;
    logic                         dispatch_ready;

    logic [SS-1:0]                cdb_valid;
    logic [SS-1:0][PREG_W-1:0]    cdb_preg;

    logic                         fu_ready;
    logic                         issue_valid;
    logic [PAYLOAD_W-1:0]         issue_payload;
    logic [PREG_W-1:0]            issue_rs1_preg;
    logic [PREG_W-1:0]            issue_rs2_preg;
    logic [FC_W-1:0]              free_count;

    modport master (
        output dispatch_valid, dispatch_payload, dispatch_rs1_preg, dispatch_rs2_preg,
        output dispatch_rs1_ready, dispatch_rs2_ready, cdb_valid, cdb_preg, fu_ready,
        input  dispatch_ready, issue_valid, issue_payload, issue_rs1_preg, issue_rs2_preg,
        input  free_count
    );

    modport slave (
        input  dispatch_valid, dispatch_payload, dispatch_rs1_preg, dispatch_rs2_preg,
        input  dispatch_rs1_ready, dispatch_rs2_ready, cdb_valid, cdb_preg, fu_ready,
        output dispatch_ready, issue_valid, issue_payload, issue_rs1_preg, issue_rs2_preg,
        output free_count
    );
endinterface

// File: rtl/reservation_station.sv
// Unified issue queue: holds renamed instructions until both sources are
// ready (cdb wakeup), then issues the lowest-indexed ready entry per cycle.
module reservation_station #(
    parameter int SS        = 2,
    parameter int RS_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    reservation_station_if.slave  rs
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int FC_W  = IDX_W + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [PREG_W-1:0]    rs1;
        logic [PREG_W-1:0]    rs2;
    } entry_data_t;

    entry_data_t             data_q [RS_DEPTH];
    logic [RS_DEPTH-1:0]     valid_q;
    logic [RS_DEPTH-1:0]     rs1_rdy_q;
    logic [RS_DEPTH-1:0]     rs2_rdy_q;
    logic [FC_W-1:0]         free_count_q;

    logic                    issue_valid_q;
    logic [PAYLOAD_W-1:0]    issue_payload_q;
    logic [PREG_W-1:0]       issue_rs1_q;
    logic [PREG_W-1:0]       issue_rs2_q;

    logic                    dispatch_ready;
    logic                    accept;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic                    do_issue;
    logic [SS-1:0]           lane_alloc;
    logic [SS-1:0][IDX_W-1:0] alloc_idx;
    logic [RS_DEPTH-1:0]     taken;
    logic [RS_DEPTH-1:0]     valid_next;
    logic [FC_W-1:0]         n_alloc;
    logic                    found;

    // A tag is satisfied by preg 0 or by any same-cycle broadcast of it.
    function automatic logic cdb_hit(input logic [PREG_W-1:0]         tag,
                                     input logic [SS-1:0]             cv,
                                     input logic [SS-1:0][PREG_W-1:0] cp);
        logic hit;
        hit = (tag == '0);
        for (int j = 0; j < SS; j++) begin
            if (cv[j] && (cp[j] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign dispatch_ready = (free_count_q >= FC_W'(SS));
    assign accept         = dispatch_ready && !flush;

    // Select works on registered state only, so a broadcast never issues in its own cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign do_issue = rs.fu_ready && sel_found && !flush;

    // Lanes claim the lowest free entries in lane order; an entry issued this
    // cycle is still marked taken, so it is reused only from the next cycle.
    always_comb begin
        taken      = valid_q;
        lane_alloc = '0;
        alloc_idx  = '0;
        n_alloc    = '0;
        found      = 1'b0;
        for (int l = 0; l < SS; l++) begin
            found = 1'b0;
            if (accept && rs.dispatch_valid[l]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!found && !taken[i]) begin
                        found        = 1'b1;
                        alloc_idx[l] = IDX_W'(i);
                    end
                end
                if (found) begin
                    lane_alloc[l]       = 1'b1;
                    taken[alloc_idx[l]] = 1'b1;
                    n_alloc             = n_alloc + FC_W'(1);
                end
            end
        end
    end

    always_comb begin
        valid_next = valid_q;
        if (do_issue) valid_next[sel_idx] = 1'b0;
        for (int l = 0; l < SS; l++) begin
            if (lane_alloc[l]) valid_next[alloc_idx[l]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid_q         <= '0;
            free_count_q    <= FC_W'(RS_DEPTH);
            issue_valid_q   <= 1'b0;
            issue_payload_q <= '0;
            issue_rs1_q     <= '0;
            issue_rs2_q     <= '0;
        end else if (flush) begin
            valid_q       <= '0;
            free_count_q  <= FC_W'(RS_DEPTH);
            issue_valid_q <= 1'b0;
        end else begin
            valid_q       <= valid_next;
            free_count_q  <= free_count_q - n_alloc + FC_W'(do_issue);
            issue_valid_q <= do_issue;
            if (do_issue) begin
                issue_payload_q <= data_q[sel_idx].payload;
                issue_rs1_q     <= data_q[sel_idx].rs1;
                issue_rs2_q     <= data_q[sel_idx].rs2;
            end
        end
    end

    // NOTE: entry storage has no reset; valid_q alone qualifies its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            rs1_rdy_q[i] <= rs1_rdy_q[i] | cdb_hit(data_q[i].rs1, rs.cdb_valid, rs.cdb_preg);
            rs2_rdy_q[i] <= rs2_rdy_q[i] | cdb_hit(data_q[i].rs2, rs.cdb_valid, rs.cdb_preg);
        end
        for (int l = 0; l < SS; l++) begin
            if (lane_alloc[l]) begin
                data_q[alloc_idx[l]]    <= '{payload: rs.dispatch_payload[l],
                                             rs1:     rs.dispatch_rs1_preg[l],
                                             rs2:     rs.dispatch_rs2_preg[l]};
                rs1_rdy_q[alloc_idx[l]] <= rs.dispatch_rs1_ready[l]
                                           | cdb_hit(rs.dispatch_rs1_preg[l], rs.cdb_valid, rs.cdb_preg);
                rs2_rdy_q[alloc_idx[l]] <= rs.dispatch_rs2_ready[l]
                                           | cdb_hit(rs.dispatch_rs2_preg[l], rs.cdb_valid, rs.cdb_preg);
            end
        end
    end

    assign rs.dispatch_ready = dispatch_ready;
    assign rs.free_count     = free_count_q;
    assign rs.issue_valid    = issue_valid_q;
    assign rs.issue_payload  = issue_payload_q;
    assign rs.issue_rs1_preg = issue_rs1_q;
    assign rs.issue_rs2_preg = issue_rs2_q;

    // Dispatching into a station that has not signalled room is a front-end bug.
    dispatch_protocol: assert property (@(posedge clk) disable iff (!rst)
        !((|rs.dispatch_valid) && !dispatch_ready));

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified issue queue that feeds fu_wrapper's single fu_input_t issue port (producer side of that interface).
- Accepts up to SS renamed instructions per cycle from dispatch and holds them until both source physical registers are ready.
- Snoops the cdb buses for wakeup.
- Issues one ready instruction per cycle: registered issue payload plus rs1/rs2 physical indices for the regfile read.

Parameters:
- SS, 2, superscalar width: dispatch lanes and cdb buses
- RS_DEPTH, 8, number of entries
- PREG_W, 6, physical register index width
- PAYLOAD_W, 128, width of opaque packed inst_info carried to fu_input_t

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous squash of all entries
- dispatch_valid  in  SS  per-lane dispatch request
- dispatch_payload  in  SS x PAYLOAD_W  packed inst_info per lane
- dispatch_rs1_preg, dispatch_rs2_preg  in  SS x PREG_W  source tags
- dispatch_rs1_ready, dispatch_rs2_ready  in  SS  source already valid (unused source dispatched as ready)
- dispatch_ready  out  1  high when free entries >= SS
- cdb_valid  in  SS  broadcast valid per bus
- cdb_preg  in  SS x PREG_W  destination tag per bus
- fu_ready  in  1  fu_wrapper can accept an instruction this cycle
- issue_valid  out  1  registered; issue_* fields valid
- issue_payload  out  PAYLOAD_W  becomes to_be_calculated.inst_info
- issue_rs1_preg, issue_rs2_preg  out  PREG_W  physical regfile read indices
- free_count  out  clog2(RS_DEPTH)+1  number of invalid entries

Behaviour:
- Reset (rst=0, async): all entry valid bits 0; issue_valid=0; issue_payload, issue_rs*_preg = 0; free_count=RS_DEPTH; dispatch_ready=1.
- Entry fields: valid, payload, rs1/rs2 tag, rs1/rs2 ready.
- dispatch_ready is combinational from registered free_count. Asserting dispatch_valid while dispatch_ready=0 is a protocol violation; assert in sim, ignore lanes.
- Allocation: when dispatch_ready, valid lanes are written in lane order (lane 0 first) into lowest-indexed free entries. Invalid lanes consume no entry.
- Wakeup: each cycle, each valid entry sets rsX_ready if any cdb_valid[j] with cdb_preg[j]==rsX tag. Ready bits never clear while the entry is valid.
- Dispatch bypass: a lane whose source tag matches a same-cycle cdb broadcast is written with that ready bit set.
- Preg 0 tag is always treated as ready.
- Select: candidate = valid entry with both ready bits set, taken from registered state, so no same-cycle cdb-to-issue. Lowest index wins.
- Issue handshake:
  - If fu_ready and a candidate exists: next cycle issue_valid=1 with that entry's payload and tags; the entry's valid bit clears at the same edge.
  - Else issue_valid=0 next cycle; issue_* fields hold their last values.
  - Minimum latency: dispatch with both sources ready at edge N → issue_valid at edge N+2.
  - Wakeup at edge N → issue_valid at edge N+2.
- Freed entries are allocatable from the next cycle, not the same cycle.
- free_count updates each edge: prev − allocated + issued. Full (0) and empty (RS_DEPTH) are both legal steady states.
- flush: at the edge, all valid bits clear, issue_valid=0, dispatch that cycle ignored, free_count=RS_DEPTH. flush overrides allocation, wakeup and issue.
- Simultaneous dispatch+issue+wakeup in one cycle must all apply independently.

Test Plan:
- Reset mid-run with 5 entries valid → outputs immediately at reset values, free_count=8; after release, dispatch of 2 ready-source instructions → issue_valid on consecutive cycles, lane 0 first.
- Dispatch lane0 rs1=p5 not ready, rs2=p0; cdb_preg[1]=p5 valid 3 cycles later → issue_valid exactly 2 edges after broadcast, issue_rs1_preg=5.
- Dispatch lane1 rs1=p9 with cdb_preg[0]=p9 same cycle → entry ready at allocation, issue at edge+2.
- Fill 8 entries, none ready → free_count=0, dispatch_ready=0; wake entry 3 → issues; dispatch_ready still 0 (1 free <2); wake another → 2 free, dispatch_ready=1.
- fu_ready=0 for 4 cycles with 3 ready entries → issue_valid=0, no entry freed; fu_ready=1 → entries 0,1,2 issue in order.
- flush while entries pending and dispatch_valid=2'b11 → next cycle issue_valid=0, free_count=8, no dispatched instruction ever issues.
